multi_cycle_adder: RTL

- Parametrised, multi-cycle add/subtract unit: adds or subtracts two WIDTH-bit operands, CHUNK bits per clock, starting from the least significant chunk.
- The carry is held in a register between chunks, so only one CHUNK-bit ripple adder (a chain of full adders) exists regardless of WIDTH.
- It extends the single-bit full-adder building block with the following: operand width, a subtract mode, signed-overflow detection and a start/busy/done handshake.
- It is the arithmetic primitive for area-constrained datapaths that can tolerate WIDTH/CHUNK cycles of latency.

---
 rtl/multi_cycle_adder_pkg.sv | 24 ++
 rtl/multi_cycle_adder_chunk_adder.sv | 26 ++
 rtl/multi_cycle_adder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/multi_cycle_adder_pkg.sv
// Shared types and elaboration helpers for the chunked add/subtract unit.
package multi_cycle_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit counter.
    function automatic int calc_cnt_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

    // One full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_adder(input logic x, input logic y, input logic ci);
        return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/multi_cycle_adder_chunk_adder.sv
// CHUNK-bit combinational ripple adder; also exposes the carry into its top bit.
module chunk_adder
    import multi_cycle_adder_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign {c[i+1], s[i]} = full_adder(x[i], y[i], c[i]);
    end

    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/multi_cycle_adder.sv
// Multi-cycle add/subtract: one shared CHUNK-bit ripple adder walks the operands LSB chunk first.
module multi_cycle_adder
    import multi_cycle_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int               NCHUNK     = calc_nchunk(WIDTH, CHUNK);
    localparam int               CNT_W      = calc_cnt_w(NCHUNK);
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [CHUNK-1:0] ch_x, ch_y, ch_s;
    logic             ch_co, ch_cmsb;
    int               sh;

    // Chunk select: bring the active chunk down to bit 0 for the shared adder.
    always_comb begin
        sh   = int'(cnt_q) * CHUNK;
        ch_x = CHUNK'(a_q >> sh);
        ch_y = CHUNK'(b_q >> sh);
    end

    chunk_adder #(
        .CHUNK(CHUNK)
    ) u_chunk_adder (
        .x    (ch_x),
        .y    (ch_y),
        .ci   (carry_q),
        .s    (ch_s),
        .co   (ch_co),
        .c_msb(ch_cmsb)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            ST_RUN: begin
                sum_d   = (sum_q & ~(CHUNK_MASK << sh)) | (WIDTH'(ch_s) << sh);
                carry_d = ch_co;
                // Counter parks on the last chunk instead of wrapping.
                if (cnt_q == LAST_CNT) begin
                    cout_d  = ch_co;
                    ovf_d   = ch_cmsb ^ ch_co;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand registers are only meaningful after an accepted start, so they carry no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule
